// File: rtl/gbe_rx_gmii_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC-32, length and
// rx_er per frame, and reports one good/bad status pulse per frame.
module gbe_rx_gmii_deframer #(
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned MIN_FRAME_LEN = 64
) (
  input  logic        mac_clk,
  input  logic        mac_rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  mac_rx_data,
  output logic        mac_rx_dvld,
  output logic        mac_rx_goodframe,
  output logic        mac_rx_badframe,
  output logic [15:0] frame_good_cnt,
  output logic [15:0] frame_bad_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {DROP, IDLE, PREAMBLE, DATA} state_t;

  state_t          state, state_nxt;
  logic [3:0]      pre_cnt;
  logic [31:0]     crc;
  logic [10:0]     len;
  logic            er_seen;
  logic [3:0][7:0] dly;
  logic [2:0]      fill;

  logic pre_start, pre_inc, frame_start, byte_acc, frame_end, frame_ok;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge mac_clk) begin
    if (mac_rst) state <= DROP;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DROP:     if (!gmii_rx_dv) state_nxt = IDLE;
      IDLE:     if (gmii_rx_dv) state_nxt = (gmii_rxd == PRE_BYTE) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!gmii_rx_dv)                                 state_nxt = IDLE;
        else if (gmii_rxd == SFD_BYTE)                   state_nxt = DATA;
        else if (gmii_rxd == PRE_BYTE && pre_cnt < 4'd7) state_nxt = PREAMBLE;
        else                                             state_nxt = DROP;
      end
      DATA:     if (!gmii_rx_dv) state_nxt = IDLE;
      default:  state_nxt = DROP;
    endcase
  end

  always_comb begin
    pre_start   = (state == IDLE)     && gmii_rx_dv && (gmii_rxd == PRE_BYTE);
    pre_inc     = (state == PREAMBLE) && gmii_rx_dv && (gmii_rxd == PRE_BYTE);
    frame_start = (state == PREAMBLE) && gmii_rx_dv && (gmii_rxd == SFD_BYTE);
    byte_acc    = (state == DATA)     && gmii_rx_dv;
    frame_end   = (state == DATA)     && !gmii_rx_dv;
    frame_ok    = (crc == CRC_RESIDUE) && !er_seen
                  && ({21'h0, len} >= MIN_FRAME_LEN) && ({21'h0, len} <= MAX_FRAME_LEN);
  end

  // A byte leaves the delay line only once four newer bytes exist, so the FCS never does.
  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      pre_cnt          <= '0;
      crc              <= '1;
      len              <= '0;
      er_seen          <= 1'b0;
      dly              <= '0;
      fill             <= '0;
      mac_rx_data      <= '0;
      mac_rx_dvld      <= 1'b0;
      mac_rx_goodframe <= 1'b0;
      mac_rx_badframe  <= 1'b0;
      frame_good_cnt   <= '0;
      frame_bad_cnt    <= '0;
    end else begin
      if (pre_start)
        pre_cnt <= 4'd1;
      else if (pre_inc && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (frame_start) begin
        crc     <= '1;
        len     <= '0;
        er_seen <= 1'b0;
        fill    <= '0;
      end else if (byte_acc) begin
        crc     <= crc32_byte(crc, gmii_rxd);
        len     <= (len == '1) ? len : len + 11'd1;
        er_seen <= er_seen | gmii_rx_er;
        dly     <= {dly[2:0], gmii_rxd};
        fill    <= (fill == 3'd4) ? fill : fill + 3'd1;
      end

      mac_rx_dvld      <= byte_acc && (fill == 3'd4);
      mac_rx_data      <= (byte_acc && (fill == 3'd4)) ? dly[3] : '0;
      mac_rx_goodframe <= frame_end && frame_ok;
      mac_rx_badframe  <= frame_end && !frame_ok;

      if (mac_rx_goodframe && frame_good_cnt != '1)
        frame_good_cnt <= frame_good_cnt + 16'd1;
      if (mac_rx_badframe && frame_bad_cnt != '1)
        frame_bad_cnt <= frame_bad_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gbe_rx_gmii_deframer.sv
// Directed bench for gbe_rx_gmii_deframer: frames built with a bench-side FCS,
// outputs captured by a negedge monitor and checked against hand-derived values.
module tb_gbe_rx_gmii_deframer;

  logic        mac_clk = 1'b0;
  logic        mac_rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_dvld;
  logic        mac_rx_goodframe;
  logic        mac_rx_badframe;
  logic [15:0] frame_good_cnt;
  logic [15:0] frame_bad_cnt;

  gbe_rx_gmii_deframer #(.MAX_FRAME_LEN(1518), .MIN_FRAME_LEN(64)) dut (
    .mac_clk(mac_clk), .mac_rst(mac_rst),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
    .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
    .frame_good_cnt(frame_good_cnt), .frame_bad_cnt(frame_bad_cnt)
  );

  always #4 mac_clk = ~mac_clk;

  int cyc = 0;
  always @(posedge mac_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] fr[$];
  logic [7:0] rxq[$];
  int n_good, n_bad, good_cyc, bad_cyc, first_out_cyc, last_out_cyc;
  int zero_viol = 0;
  int first_da_cyc, e_cyc;

  always @(negedge mac_clk) begin
    if (mac_rx_dvld) begin
      rxq.push_back(mac_rx_data);
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end else if (mac_rx_data != 8'h00) begin
      zero_viol++;
    end
    if (mac_rx_goodframe) begin n_good++; good_cyc = cyc; end
    if (mac_rx_badframe)  begin n_bad++;  bad_cyc  = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    rxq.delete();
    n_good = 0; n_bad = 0; good_cyc = -1; bad_cyc = -1;
    first_out_cyc = -1; last_out_cyc = -1;
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(negedge mac_clk);
    gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Payload followed by the FCS (complemented CRC, least significant byte first).
  task automatic build_frame(input int plen, input int seed);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < plen; i++) fr.push_back(8'(i * 13 + seed));
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_step(c, fr[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
  endtask

  task automatic send(input int npre, input logic [7:0] sfd, input int er_idx,
                      input int rst_idx, input int gap);
    for (int p = 0; p < npre; p++) drive(8'h55, 1'b1, 1'b0);
    drive(sfd, 1'b1, 1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      drive(fr[i], 1'b1, (i == er_idx));
      if (i == 0) first_da_cyc = cyc;
      if (i == rst_idx) mac_rst = 1'b1;
      if (rst_idx >= 0 && i == rst_idx + 1) begin
        mac_rst = 1'b0;
        chk("rst_outs", {mac_rx_dvld, mac_rx_data, mac_rx_goodframe, mac_rx_badframe}, 0);
        chk("rst_cnts", {frame_good_cnt, frame_bad_cnt}, 0);
        mon_clear();
      end
    end
    drive(8'h00, 1'b0, 1'b0);
    e_cyc = cyc;
    idle(gap - 1);
  endtask

  task automatic check_frame(input string tag, input int nbytes, input bit good);
    int mism;
    chk({tag, "_nbytes"}, rxq.size(), nbytes);
    if (nbytes > 0) begin
      mism = 0;
      for (int i = 0; i < rxq.size() && i < fr.size(); i++)
        if (rxq[i] !== fr[i]) mism++;
      chk({tag, "_data"}, mism, 0);
      chk({tag, "_latency"}, first_out_cyc - first_da_cyc, 5);
      chk({tag, "_contig"}, last_out_cyc - first_out_cyc + 1, nbytes);
      chk({tag, "_pulse_after_dvld"}, good ? good_cyc : bad_cyc, last_out_cyc + 1);
    end
    chk({tag, "_pulses"}, {n_good[15:0], n_bad[15:0]}, good ? 32'h0001_0000 : 32'h0000_0001);
    chk({tag, "_pulse_cyc"}, good ? good_cyc : bad_cyc, e_cyc + 1);
  endtask

  initial begin
    mac_rst = 1'b1; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    mon_clear();
    idle(2);
    mac_rst = 1'b0;
    idle(1);
    chk("reset_outs", {mac_rx_dvld, mac_rx_data, mac_rx_goodframe, mac_rx_badframe}, 0);
    chk("reset_cnts", {frame_good_cnt, frame_bad_cnt}, 0);
    idle(3);

    mon_clear(); build_frame(60, 1);
    send(7, 8'hD5, -1, -1, 8);
    check_frame("good64", 60, 1'b1);
    chk("good64_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0001_0000);

    mon_clear(); build_frame(60, 1); fr[10] = fr[10] ^ 8'h04;
    send(7, 8'hD5, -1, -1, 8);
    check_frame("bitflip", 60, 1'b0);
    chk("bitflip_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0001_0001);

    mon_clear(); build_frame(60, 9);
    send(7, 8'hD5, 20, -1, 8);
    check_frame("rx_er", 60, 1'b0);
    chk("rx_er_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0001_0002);

    mon_clear(); build_frame(36, 3);
    send(7, 8'hD5, -1, -1, 8);
    check_frame("runt40", 36, 1'b0);

    mon_clear(); fr.delete(); fr.push_back(8'hA1); fr.push_back(8'hB2); fr.push_back(8'hC3);
    send(7, 8'hD5, -1, -1, 8);
    check_frame("runt3", 0, 1'b0);

    mon_clear(); build_frame(1596, 7);
    send(7, 8'hD5, -1, -1, 8);
    check_frame("giant1600", 1596, 1'b0);
    chk("giant_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0001_0005);

    mon_clear(); build_frame(60, 2);
    send(0, 8'h12, -1, -1, 8);
    send(9, 8'hD5, -1, -1, 8);
    chk("drop_nbytes", rxq.size(), 0);
    chk("drop_pulses", n_good + n_bad, 0);
    chk("drop_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0001_0005);
    mon_clear();
    send(7, 8'hD5, -1, -1, 8);
    check_frame("after_drop", 60, 1'b1);
    chk("after_drop_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0002_0005);

    mon_clear(); build_frame(60, 4);
    send(7, 8'hD5, -1, 30, 1);
    send(7, 8'hD5, -1, -1, 8);
    check_frame("after_rst", 60, 1'b1);
    chk("after_rst_cnts", {frame_good_cnt, frame_bad_cnt}, 32'h0001_0000);

    chk("data_zero_when_idle", zero_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gbe_rx_gmii_deframer.md
GBE_RX_GMII_DEFRAMER -- requirements
Module: gbe_rx_gmii_deframer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1518, maximum legal frame length in bytes (DA through FCS inclusive).
REQ-002 SHALL have parameter MIN_FRAME_LEN, default 64, minimum legal frame length in bytes (DA through FCS inclusive).
REQ-003 SHALL have ports, one per line:
  mac_clk  in  1  sole clock; all logic on rising edge.
  mac_rst  in  1  synchronous, active-high reset.
  gmii_rxd  in  8  GMII receive byte.
  gmii_rx_dv  in  1  GMII receive data valid.
  gmii_rx_er  in  1  GMII receive error.
  mac_rx_data  out  8  frame byte, DA onward, FCS stripped.
  mac_rx_dvld  out  1  mac_rx_data valid; contiguous per frame.
  mac_rx_goodframe  out  1  one-cycle pulse: completed frame passed all checks.
  mac_rx_badframe  out  1  one-cycle pulse: completed frame failed a check.
  frame_good_cnt  out  16  count of goodframe pulses.
  frame_bad_cnt  out  16  count of badframe pulses.

Function
REQ-004 SHALL implement states DROP, IDLE, PREAMBLE and DATA.
REQ-005 DROP SHALL go to IDLE in the first cycle gmii_rx_dv=0; no output and no status pulse while in DROP.
REQ-006 IDLE transitions:
  - gmii_rx_dv=1 and rxd=0x55: go to PREAMBLE.
  - gmii_rx_dv=1 and any other byte: go to DROP.
REQ-007 PREAMBLE transitions:
  - rxd=0x55: stay, counting bytes.
  - rxd=0xD5 with gmii_rx_dv=1: go to DATA.
  - more than 7 bytes of 0x55, any other byte, or gmii_rx_dv=0: go to DROP (or IDLE if gmii_rx_dv=0).
REQ-008 DATA SHALL accept one byte per cycle while gmii_rx_dv=1; the first cycle with gmii_rx_dv=0 (cycle e) SHALL end the frame and return to IDLE.
REQ-009 Bytes SHALL pass through a 4-byte delay line so the last 4 bytes (FCS) are never emitted.
  - For a frame of N bytes, N>=5: exactly N-4 bytes emitted on consecutive cycles.
  - Fixed latency of 5 cycles from gmii_rxd to mac_rx_data.
REQ-010 A frame with N<=4 SHALL emit no bytes.
REQ-011 CRC-32 SHALL use reflected polynomial 0xEDB88320, LSB-first, init 0xFFFFFFFF per frame, computed over all N bytes; the frame is CRC-good iff the final register equals 0xDEBB20E3.
REQ-012 The frame length counter SHALL be 11 bits and saturate at 2047.
REQ-013 The frame is bad if any of the following holds:
  - CRC not good.
  - gmii_rx_er=1 in any DATA cycle with gmii_rx_dv=1.
  - N<MIN_FRAME_LEN.
  - N>MAX_FRAME_LEN.
  Otherwise the frame is good.
REQ-014 Exactly one of mac_rx_goodframe/mac_rx_badframe SHALL pulse high for one cycle at cycle e+1 for every frame that reached DATA, including N<=4.
REQ-015 The e+1 pulse is the cycle after the last mac_rx_dvld=1 cycle when N>=5.
REQ-016 Oversize and errored frames SHALL still emit their bytes; only the status pulse reports failure.
REQ-017 gmii_rx_er with gmii_rx_dv=0 SHALL be ignored.
REQ-018 Back-to-back frames with 1-cycle dv-low gap SHALL be handled; the status pulse of frame k may overlap preamble of frame k+1, never its data.
REQ-019 mac_rx_data SHALL hold 0x00 whenever mac_rx_dvld=0.
REQ-020 frame_good_cnt SHALL increment on each goodframe pulse and frame_bad_cnt on each badframe pulse; both saturate at 0xFFFF.

Reset
REQ-021 On mac_rst=1 at a clock edge, the next cycle SHALL have all outputs 0, both counters 0, CRC/length/delay line cleared, and state DROP.
REQ-022 A frame in progress at reset SHALL produce no further bytes and no status pulse; its remaining bytes are discarded via DROP.

Verification
REQ-023 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 60 bytes out in order at latency 5, contiguous dvld; goodframe at e+1; frame_good_cnt=1.
REQ-024 Same frame with one payload bit flipped -> 60 bytes out; badframe at e+1; frame_bad_cnt=1, frame_good_cnt unchanged.
REQ-025 64-byte frame, correct FCS, gmii_rx_er=1 on byte 20 -> 60 bytes out; badframe.
REQ-026 Runt with valid FCS, N=40 -> 36 bytes out, badframe; N=3 -> no bytes, badframe at e+1; 1600-byte frame -> 1596 bytes out, badframe.
REQ-027 dv=1 with first byte 0x12, and preamble of 9x0x55 -> no bytes, no pulses, counters unchanged; following good frame -> goodframe.
REQ-028 mac_rst for 1 cycle at byte 30 of a frame -> outputs 0 next cycle, no pulse for that frame; next good frame after 1-cycle IFG -> goodframe, frame_good_cnt=1.
